// File: rtl/soldnum_pkg.sv
// soldnum_pkg: glyphs, segment bit order and scan slots shared by
// soldnum_scan_display and its helpers.
package soldnum_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [7:0] glyph_t;

    // Active-high glyphs for 0..F, entry 0 in the low byte
    localparam logic [15:0][7:0] GLYPH_HEX = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    localparam glyph_t GLYPH_H     = 8'h76;
    localparam glyph_t GLYPH_DASH  = 8'(1 << SEG_G);
    localparam glyph_t GLYPH_DP    = 8'(1 << SEG_DP);
    localparam glyph_t GLYPH_BLANK = 8'h00;

    localparam logic [2:0] SLOT_SEP  = 3'd5;
    localparam logic [2:0] SLOT_LANE = 3'd6;
    localparam logic [2:0] SLOT_H    = 3'd7;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle double-dabble binary to BCD engine.
// One shift/add-3 step per clock; done marks the commit cycle.
module bin2bcd_seq #(
    parameter int CNT_W = 10,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                EN,
    input  logic                start,
    input  logic [CNT_W-1:0]    bin,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);

    localparam int W  = 4 * NDIG + CNT_W;
    localparam int CW = $clog2(CNT_W + 1);

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;
    logic          run;

    function automatic logic [W-1:0] dabble(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int d = 0; d < NDIG; d++) begin
            if (r[CNT_W+4*d +: 4] > 4'd4)
                r[CNT_W+4*d +: 4] = r[CNT_W+4*d +: 4] + 4'd3;
        end
        return r << 1;
    endfunction

    always_ff @(posedge clk or negedge EN) begin
        if (!EN) begin
            sr  <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sr  <= W'(bin);
            cnt <= CW'(CNT_W);
            run <= 1'b1;
        end else if (run) begin
            if (cnt != '0) begin
                sr  <= dabble(sr);
                cnt <= cnt - CW'(1);
            end else begin
                run <= 1'b0;
            end
        end
    end

    assign done = run && (cnt == '0);
    assign bcd  = sr[W-1 -: 4*NDIG];

endmodule

// File: rtl/soldnum_scan_display.sv
// soldnum_scan_display: double-buffered 8-digit scan driver for one lane's
// sold count. Define SOLDNUM_LZB_EN to blank leading zero count digits.
import soldnum_pkg::*;

module soldnum_scan_display #(
    parameter int SCAN_DIV = 25000,
    parameter int CNT_W    = 10,
    parameter int NDIG     = 3,
    parameter int LANE_W   = 3
) (
    input  logic              clk,
    input  logic              EN,
    input  logic [LANE_W-1:0] lane,
    input  logic [CNT_W-1:0]  sold,
    input  logic              load,
    output logic              busy,
    output logic [7:0]        seg_en,
    output logic [7:0]        seg_out
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [31:0] DEC_MAX = 32'(pow10(NDIG) - 1);
`ifdef SOLDNUM_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic              capture, commit, restart, start;
    logic              done, pending, tick;
    logic              in_ovf, sh_ovf;
    logic [LANE_W-1:0] in_lane, sh_lane;
    logic [4*NDIG-1:0] bcd, sh_bcd;
    logic [DW-1:0]     div;
    logic [2:0]        idx;
    logic [31:0]       bcd_pad;
    logic [3:0]        dig;
    glyph_t            glyph;

    assign capture = load && !busy;
    assign commit  = busy && done;
    // A load on the commit cycle itself is folded into the re-sample
    assign restart = commit && (pending || load);
    assign start   = capture || restart;
    assign tick    = (div == DIV_LAST);

    bin2bcd_seq #(
        .CNT_W (CNT_W),
        .NDIG  (NDIG)
    ) u_bcd (
        .clk   (clk),
        .EN    (EN),
        .start (start),
        .bin   (sold),
        .done  (done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge EN) begin
        if (!EN) begin
            busy    <= 1'b0;
            pending <= 1'b0;
            in_lane <= '0;
            in_ovf  <= 1'b0;
            sh_bcd  <= '0;
            sh_lane <= '0;
            sh_ovf  <= 1'b0;
        end else begin
            if (start) begin
                in_lane <= lane;
                in_ovf  <= 32'(sold) > DEC_MAX;
            end
            if (capture) busy <= 1'b1;
            if (commit) begin
                sh_bcd  <= bcd;
                sh_lane <= in_lane;
                sh_ovf  <= in_ovf;
                busy    <= restart;
                pending <= 1'b0;
            end else if (load && busy) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        bcd_pad = 32'(sh_bcd);
        dig     = bcd_pad[{idx, 2'b00} +: 4];
        glyph   = GLYPH_BLANK;
        unique case (1'b1)
            idx == SLOT_H:    glyph = GLYPH_H;
            idx == SLOT_LANE: glyph = GLYPH_HEX[4'(sh_lane)];
            idx == SLOT_SEP:  glyph = GLYPH_DP;
            int'(idx) < NDIG: begin
                if (sh_ovf)
                    glyph = GLYPH_DASH;
                else if (LZB && idx != 3'd0 &&
                         (bcd_pad >> {idx, 2'b00}) == 32'd0)
                    glyph = GLYPH_BLANK;
                else
                    glyph = GLYPH_HEX[dig];
            end
            default: glyph = GLYPH_BLANK;
        endcase
    end

    // Enable and segments load on the same edge, so they never disagree
    always_ff @(posedge clk or negedge EN) begin
        if (!EN) begin
            div     <= '0;
            idx     <= 3'd0;
            seg_en  <= 8'hFF;
            seg_out <= 8'hFF;
        end else if (tick) begin
            div     <= '0;
            idx     <= idx + 3'd1;
            seg_en  <= ~(8'd1 << idx);
            seg_out <= ~glyph;
        end else begin
            div <= div + DW'(1);
        end
    end

endmodule

// File: tb/tb_soldnum_scan_display.sv
// tb_soldnum_scan_display: randomized and directed checks of the scan
// display against a decimal-arithmetic reference model.
module tb_soldnum_scan_display;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 10;
    localparam int NDIG     = 3;
    localparam int LANE_W   = 3;
    localparam int CONV     = CNT_W + 1;
`ifdef SOLDNUM_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              EN = 1'b0;
    logic              load = 1'b0;
    logic [LANE_W-1:0] lane = '0;
    logic [CNT_W-1:0]  sold = '0;
    logic              busy;
    logic [7:0]        seg_en, seg_out;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] frame [8];

    always #5 clk = ~clk;

    soldnum_scan_display #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W),
        .NDIG     (NDIG),
        .LANE_W   (LANE_W)
    ) dut (
        .clk     (clk),
        .EN      (EN),
        .lane    (lane),
        .sold    (sold),
        .load    (load),
        .busy    (busy),
        .seg_en  (seg_en),
        .seg_out (seg_out)
    );

    function automatic logic [7:0] seven(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;
            3: return 8'h4F;  4: return 8'h66;  5: return 8'h6D;
            6: return 8'h7D;  7: return 8'h07;  8: return 8'h7F;
            9: return 8'h6F;  10: return 8'h77; 11: return 8'h7C;
            12: return 8'h39; 13: return 8'h5E; 14: return 8'h79;
            default: return 8'h71;
        endcase
    endfunction

    // Expected active-low segments for one slot of the displayed frame
    function automatic logic [7:0] model_seg(input int slot, input int ln,
                                             input int val);
        logic [7:0] g;
        if (slot == 7)                      g = 8'h76;
        else if (slot == 6)                 g = seven(ln);
        else if (slot == 5)                 g = 8'h80;
        else if (slot >= NDIG)              g = 8'h00;
        else if (val >= 10 ** NDIG)         g = 8'h40;
        else if (LZB && slot > 0 && val < 10 ** slot) g = 8'h00;
        else g = seven((val / (10 ** slot)) % 10);
        return ~g;
    endfunction

    task automatic capture_frame();
        for (int i = 0; i < 8; i++) frame[i] = 'x;
        repeat (8 * SCAN_DIV) @(negedge clk);
        for (int c = 0; c < 8 * SCAN_DIV; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++)
                if (seg_en == ~(8'd1 << i)) frame[i] = seg_out;
        end
    endtask

    task automatic run_load(input int ln, input int val, output int cyc);
        @(negedge clk);
        lane = LANE_W'(ln);
        sold = CNT_W'(val);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        EN = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (seg_en !== 8'hFF || seg_out !== 8'hFF || busy !== 1'b0)
            $display("FAIL reset_hold en=%h seg=%h busy=%b want FF FF 0",
                     seg_en, seg_out, busy);
        else n_pass++;
        EN = 1'b1;
        for (int k = 0; k < SCAN_DIV - 1; k++) begin
            @(negedge clk);
            n_total++;
            if (seg_en !== 8'hFF || seg_out !== 8'hFF)
                $display("FAIL reset_dark c%0d en=%h seg=%h want FF FF",
                         k, seg_en, seg_out);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (seg_en !== 8'hFE || seg_out !== model_seg(0, 0, 0))
            $display("FAIL first_tick en=%h seg=%h want FE %h",
                     seg_en, seg_out, model_seg(0, 0, 0));
        else n_pass++;
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (frame[i] !== model_seg(i, 0, 0))
                $display("FAIL reset_frame slot%0d got %h want %h",
                         i, frame[i], model_seg(i, 0, 0));
            else n_pass++;
        end
    endtask

    task automatic test_value(input string name, input int ln,
                              input int val);
        int cyc;
        run_load(ln, val, cyc);
        n_total++;
        if (cyc != CONV)
            $display("FAIL %s_busy got %0d cycles want %0d", name, cyc, CONV);
        else n_pass++;
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (frame[i] !== model_seg(i, ln, val))
                $display("FAIL %s slot%0d val=%0d got %h want %h",
                         name, i, val, frame[i], model_seg(i, ln, val));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        lane = 3'd2;
        sold = 10'd7;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            load = (cyc == 3 || cyc == 5 || cyc == 7);
            if (cyc == 3) sold = 10'd42;
            cyc++;
            @(negedge clk);
        end
        load = 1'b0;
        n_total++;
        if (cyc != 2 * CONV)
            $display("FAIL b2b_busy got %0d cycles want %0d", cyc, 2 * CONV);
        else n_pass++;
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (frame[i] !== model_seg(i, 2, 42))
                $display("FAIL b2b slot%0d got %h want %h",
                         i, frame[i], model_seg(i, 2, 42));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lane = 3'd6;
        sold = 10'd500;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        EN = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || seg_en !== 8'hFF)
            $display("FAIL mid_reset busy=%b en=%h want 0 FF", busy, seg_en);
        else n_pass++;
        repeat (3) @(negedge clk);
        EN = 1'b1;
        repeat (2 * CONV) @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL mid_idle busy=%b want 0", busy);
        else n_pass++;
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (frame[i] !== model_seg(i, 0, 0))
                $display("FAIL mid_frame slot%0d got %h want %h",
                         i, frame[i], model_seg(i, 0, 0));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int v, ln;
            v  = int'($urandom_range(0, 1023));
            ln = int'($urandom_range(0, 7));
            test_value("rand", ln, v);
        end
    endtask

    initial begin
        test_reset();
        test_value("basic", 3, 305);
        test_value("overflow", 5, 1000);
        test_value("max", 7, 999);
        test_back_to_back();
        test_value("lzb", 1, 9);
        test_value("zero", 4, 0);
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/soldnum_scan_display.md
# soldnum_scan_display

Parametrised successor to the single-lane sold-count display: an eight-digit, time-multiplexed seven-segment driver that shows one lane's sold count as a configurable number of decimal digits.
- Input is a binary count, converted to BCD by a sequential double-dabble engine.
- The display is double-buffered, so digits never tear while a conversion runs.
- Overflow shows dashes; leading zeros are optionally blanked.
- Sits between the sales-record store and the board's 8-digit display, alongside the other display_* blocks selected by the top-level mode mux.

## Interface
Parameters:
- SCAN_DIV, 25000: clk cycles per digit slot; legal range ≥ 2.
- CNT_W, 10: width of the binary sold count; legal range 1..17.
- NDIG, 3: decimal count digits shown; legal range 1..5.
- LANE_W, 3: lane number width; legal range 1..4, shown as hex.

Ports:
- clk  in  1  system clock.
- EN  in  1  asynchronous active-low reset; low clears all state.
- lane  in  LANE_W  lane number to show.
- sold  in  CNT_W  binary sold count of that lane.
- load  in  1  single-cycle request to capture lane/sold.
- busy  out  1  conversion in progress.
- seg_en  out  8  digit enables, active-low; bit i selects digit i.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Capture and convert:
  - On a clk edge with load=1 and busy=0, lane and sold are latched into input registers and busy rises.
  - The converter then runs CNT_W shift/add-3 cycles, followed by one commit cycle.
  - On the commit cycle, the shadow registers (BCD digits, lane, overflow flag) update and busy falls.
- load while busy=1 sets a pending flag; it does not abort the running conversion.
  - On commit, if pending=1, lane/sold are re-sampled the same cycle, busy stays 1 and a new conversion starts.
  - Multiple loads while busy collapse into one re-sample.
- Overflow: captured sold > 10^NDIG − 1 sets the shadow overflow flag; all count digits then show dash (g only).
- Scan: a free-running divider asserts a tick when it reaches SCAN_DIV−1, then wraps to 0.
  - Scan index 0..7 advances on each tick; 7 wraps to 0.
- Digit map for scan index i:
  - i < NDIG: BCD digit i of the shadow (i=0 is units).
  - NDIG ≤ i ≤ 4: blank.
  - 5: dp only (separator).
  - 6: shadow lane as a hex glyph.
  - 7: letter H.
- Glyphs are standard seven-segment: 6 includes segment a, 7 is a,b,c, 9 includes d.
- Shadow count is zero at reset, so count digits show 0 (or blank, see Configuration).

## Timing
- Reset values (EN low, asynchronous):
  - seg_en=8'hFF and seg_out=8'hFF (display dark).
  - busy=0, pending=0.
  - Divider=0, scan index=0.
  - Shadow digits=0, shadow lane=0, overflow=0.
- First tick after reset release: SCAN_DIV cycles.
- seg_en/seg_out are registered and change one cycle after the tick, together. There is no cycle where seg_en selects a digit while seg_out still carries the previous digit's segments.
- Conversion latency: load edge to shadow update = CNT_W+1 cycles; busy is high for exactly CNT_W+1 cycles per conversion.
- A shadow update takes effect at the next digit slot. There is no mid-slot glitch beyond the single-cycle register update.
- Reset mid-conversion: the conversion is discarded and the shadow returns to 0.
- The divider and scan index are unaffected by load/busy.

## Configuration
- SOLDNUM_LZB_EN defined: count digits above the most significant non-zero digit are blank. A count of 0 shows a single 0 at digit 0. Dashes on overflow are unaffected.
- SOLDNUM_LZB_EN undefined: all NDIG count digits are shown, including leading zeros (the fixed-width behaviour of the previous block).

## Structure
- Package soldnum_pkg holds:
  - the 8-bit active-high glyph constants: digits 0–F, H, dash, dp, blank;
  - the segment bit-order localparams;
  - the scan slot indices (separator 5, lane 6, H 7).
- Sub-module bin2bcd_seq:
  - parameters CNT_W and NDIG;
  - ports clk, EN, start, bin, done, bcd[4*NDIG-1:0];
  - multi-cycle double-dabble engine.
- The top block holds the divider, scan index, pending flag, shadow registers, digit mux and output inversion.

## Test plan
- Reset: hold EN low for 5 cycles, release -> seg_en=8'hFF and seg_out=8'hFF until the first tick, busy=0; after ticks, digit 0 shows 0, digit 7 shows H.
- Basic load (SCAN_DIV=4, CNT_W=10, NDIG=3): load with sold=10'd305, lane=3 -> busy high for 11 cycles; scan then shows:
  - seg_en=8'hFE with glyph 5, 8'hFD with glyph 0, 8'hFB with glyph 3;
  - digit 5 dp, digit 6 glyph 3, digit 7 H.
- Overflow: sold=10'd1000 -> digits 0–2 each seg_out=~8'h40 (dash); lane and H are unaffected.
- Load while busy: load sold=7, then load sold=42 three cycles later -> shadow shows 7 at cycle 11. busy stays high, and the shadow shows 42 after a further 11 cycles.
- Leading-zero option: sold=9 with SOLDNUM_LZB_EN -> digits 1,2 blank; without it -> digits 1,2 show 0.
- Reset mid-conversion: pull EN low 4 cycles after load -> busy=0 and the shadow reads 0 after release.
